// File: rtl/conv_encoder_punct.sv
// K-constraint two-generator convolutional encoder with 802.11a puncturing
// (rates 1/2, 2/3, 3/4) feeding a show-ahead output bit FIFO.
//
// Ports:
//   Clk, reset      rising-edge clock, async active-low reset
//   en              global enable, 0 freezes all state
//   rate, sof       rate select (sampled on sof beat), start of frame
//   in_valid/in_ready/data_in     uncoded input handshake
//   out_valid/out_ready/out_bit   coded output handshake (FIFO head)
//   fifo_count      FIFO occupancy
//   rate_err        one-cycle pulse after an sof beat carrying rate=3
module conv_encoder_punct #(
    parameter int          K          = 7,
    parameter logic [K-1:0] G0        = 7'o133,
    parameter logic [K-1:0] G1        = 7'o171,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [1:0]                    rate,
    input  logic                          sof,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          data_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_bit,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rate_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [K-2:0]    r_sr;
    logic [1:0]      r_phase;
    logic [1:0]      r_rate;
    logic            r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;
    logic            r_rate_err;
    logic            r_live;

    logic            w_acc;
    logic            w_pop;
    logic            w_nz;
    logic [CW-1:0]   w_free;
    logic [K-2:0]    w_hist;
    logic [K-1:0]    w_v;
    logic            w_a;
    logic            w_b;
    logic [1:0]      w_rate_in;
    logic [1:0]      w_rate;
    logic [1:0]      w_phase;
    logic [1:0]      w_nb;
    logic            w_b0;
    logic            w_b1;
    logic [1:0]      w_nph;
    logic [AW-1:0]   w_wp1;
    logic [CW-1:0]   w_add;

    assign w_nz      = (r_cnt != '0);
    assign w_free    = CW'(FIFO_DEPTH) - r_cnt;
    // r_live keeps in_ready low while reset is asserted
    assign in_ready  = en & r_live & (w_free >= CW'(2));
    assign out_valid = en & w_nz;
    assign out_bit   = w_nz & r_mem[r_rp];
    assign fifo_count = r_cnt;
    assign rate_err  = r_rate_err;

    assign w_acc = in_valid & in_ready;
    assign w_pop = out_valid & out_ready;

    // sof restarts the code from the all-zero state
    assign w_hist = sof ? '0 : r_sr;
    assign w_v    = {data_in, w_hist};
    assign w_a    = ^(w_v & G0);
    assign w_b    = ^(w_v & G1);

    assign w_rate_in = (rate == 2'd3) ? 2'd0 : rate;
    assign w_rate    = sof ? w_rate_in : r_rate;
    assign w_phase   = sof ? 2'd0 : r_phase;

    always_comb begin
        w_nb  = 2'd2;
        w_b0  = w_a;
        w_b1  = w_b;
        w_nph = 2'd0;
        case (w_rate)
            2'd1: begin
                if (w_phase == 2'd0) begin
                    w_nph = 2'd1;
                end else begin
                    w_nb = 2'd1;
                end
            end
            2'd2: begin
                case (w_phase)
                    2'd0: w_nph = 2'd1;
                    2'd1: begin
                        w_nb  = 2'd1;
                        w_nph = 2'd2;
                    end
                    default: begin
                        w_nb = 2'd1;
                        w_b0 = w_b;
                    end
                endcase
            end
            default: ;
        endcase
    end

    assign w_wp1 = r_wp + AW'(1);
    assign w_add = w_acc ? CW'(w_nb) : '0;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_sr       <= '0;
            r_phase    <= 2'd0;
            r_rate     <= 2'd0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_rate_err <= 1'b0;
            r_live     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 1'b0;
            end
        end else begin
            r_live     <= 1'b1;
            r_rate_err <= w_acc & sof & (rate == 2'd3);
            if (w_acc) begin
                r_sr    <= w_v[K-1:1];
                r_phase <= w_nph;
                if (sof) begin
                    r_rate <= w_rate_in;
                end
                r_mem[r_wp] <= w_b0;
                if (w_nb == 2'd2) begin
                    r_mem[w_wp1] <= w_b1;
                end
                r_wp <= r_wp + AW'(w_nb);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            r_cnt <= r_cnt + w_add - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Directed bench for conv_encoder_punct: impulse responses per rate,
// backpressure, enable freeze, reserved rate and mid-frame reset.
module tb_conv_encoder_punct;

    logic       Clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] rate;
    logic       sof;
    logic       in_valid;
    logic       in_ready;
    logic       data_in;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic [3:0] fifo_count;
    logic       rate_err;

    int tests = 0;
    int fails = 0;
    bit q[$];

    conv_encoder_punct dut (
        .Clk        (Clk),
        .reset      (reset),
        .en         (en),
        .rate       (rate),
        .sof        (sof),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .fifo_count (fifo_count),
        .rate_err   (rate_err)
    );

    always #5 Clk = ~Clk;

    // Capture each bit that will pop at the next rising edge
    always @(negedge Clk) begin
        if (out_valid && out_ready) q.push_back(out_bit);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic s, input logic [1:0] r,
                        input logic d);
        int n;
        n = 0;
        in_valid = 1'b1;
        sof      = s;
        rate     = r;
        data_in  = d;
        while (!in_ready && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        check("send_ready", in_ready, 1);
        @(posedge Clk); #1;
        in_valid = 1'b0;
        sof      = 1'b0;
        rate     = 2'd0;
    endtask

    task automatic drain(input string tag, input int len,
                         input logic [31:0] exp);
        int n;
        logic [31:0] got;
        n = 0;
        got = '0;
        while (fifo_count != 0 && n < 200) begin
            @(posedge Clk); #1;
            n++;
        end
        check({tag, "_empty"}, fifo_count, 0);
        foreach (q[i]) got = {got[30:0], q[i]};
        check({tag, "_len"}, q.size(), len);
        check({tag, "_bits"}, got, exp);
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; rate = 2'd0; sof = 1'b0;
        in_valid = 1'b0; data_in = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_rate_err", rate_err, 0);
        check("rst_out_bit", out_bit, 0);
        @(negedge Clk); reset = 1'b1;
        @(posedge Clk); #1;

        // Impulse, rate 1/2
        out_ready = 1'b1;
        q.delete();
        send(1'b1, 2'd0, 1'b1);
        check("lat_valid", out_valid, 1);
        check("lat_bit", out_bit, 1);
        check("lat_count", fifo_count, 2);
        check("r0_no_err", rate_err, 0);
        repeat (6) send(1'b0, 2'd0, 1'b0);
        drain("imp_r0", 14, 32'b11011111001011);

        // Impulse, rate 3/4
        q.delete();
        send(1'b1, 2'd2, 1'b1);
        repeat (5) send(1'b0, 2'd0, 1'b0);
        drain("imp_r2", 8, 32'b11011100);

        // Reserved rate behaves as 1/2 and flags an error once
        q.delete();
        send(1'b1, 2'd3, 1'b1);
        check("r3_err_hi", rate_err, 1);
        send(1'b0, 2'd0, 1'b0);
        check("r3_err_lo", rate_err, 0);
        repeat (5) send(1'b0, 2'd0, 1'b0);
        drain("imp_r3", 14, 32'b11011111001011);

        // Rate 2/3, four ones
        q.delete();
        send(1'b1, 2'd1, 1'b1);
        repeat (3) send(1'b0, 2'd0, 1'b1);
        drain("ones_r1", 6, 32'b111011);

        // Reset mid-frame with 5 bits queued
        out_ready = 1'b0;
        send(1'b1, 2'd1, 1'b1);
        send(1'b0, 2'd0, 1'b1);
        send(1'b0, 2'd0, 1'b0);
        check("pre_rst_count", fifo_count, 5);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        @(negedge Clk); reset = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b1;
        q.delete();
        send(1'b1, 2'd0, 1'b1);
        repeat (6) send(1'b0, 2'd0, 1'b0);
        drain("post_rst", 14, 32'b11011111001011);

        // Backpressure and enable freeze, rate 1/2, input 1,0,1,1
        out_ready = 1'b0;
        q.delete();
        send(1'b1, 2'd0, 1'b1);
        send(1'b0, 2'd0, 1'b0);
        send(1'b0, 2'd0, 1'b1);
        send(1'b0, 2'd0, 1'b1);
        check("bp_full", fifo_count, 8);
        check("bp_not_ready", in_ready, 0);
        in_valid = 1'b1; data_in = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
        end
        in_valid = 1'b0;
        check("bp_hold", fifo_count, 8);
        en = 1'b0; out_ready = 1'b1;
        #1;
        check("en0_valid", out_valid, 0);
        check("en0_ready", in_ready, 0);
        @(posedge Clk); #1;
        check("en0_count", fifo_count, 8);
        en = 1'b1;
        drain("bp", 8, 32'b11010001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_encoder_punct.md
Name: conv_encoder_punct

Overview:
Parametrised successor to the fixed rate-1/2 802.11a convolutional encoder. Computes the two-generator convolutional code (K=7, g0=133o, g1=171o by default), applies 802.11a puncturing for rates 1/2, 2/3 and 3/4, and serialises the coded bits through an internal bit FIFO. Both sides use valid/ready handshakes. Sits between the scrambler and the interleaver in the TX chain.

Parameters:
K, 7, constraint length; shift register holds K-1 past bits; legal range 3..9.
G0, 7'o133, generator A; bit K-1 taps the current input, bit K-1-i taps input delayed by i.
G1, 7'o171, generator B; same convention as G0.
FIFO_DEPTH, 8, output bit FIFO depth; power of 2, at least 4.

Ports:
Clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
en  in  1  global enable; 0 freezes all state.
rate  in  2  0=1/2, 1=2/3, 2=3/4, 3=reserved; sampled only on an sof beat.
sof  in  1  start of frame; qualified by in_valid & in_ready.
in_valid  in  1  data_in valid.
in_ready  out  1  encoder accepts data_in this cycle.
data_in  in  1  uncoded bit.
out_valid  out  1  out_bit valid.
out_ready  in  1  downstream accepts out_bit.
out_bit  out  1  coded, punctured bit, head of FIFO.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
rate_err  out  1  one-cycle pulse when an sof beat carries rate=3.

Behaviour:
- Reset (reset=0, asynchronous):
  - shift register, puncture phase, latched rate, FIFO pointers and count all cleared.
  - in_ready=0, out_valid=0, out_bit=0, fifo_count=0, rate_err=0.
- en=0: no state changes; in_ready=0 and out_valid=0 (combinational force). FIFO contents and phase are retained.
- in_ready = en & (FIFO free slots >= 2). This is registered-free, so in_ready is combinational from fifo_count and en.
- Accept beat = in_valid & in_ready.
- On an accept beat, v = {data_in, s[0..K-2]}, with s[j] the input delayed by j+1. A = ^(v & G0), B = ^(v & G1). Then s shifts, with s[0] <= data_in.
- sof on an accept beat:
  - shift register treated as all-zero for this bit's computation.
  - phase forced to 0.
  - rate latched from the rate port; rate=3 latches as 0 and pulses rate_err on the next cycle.
- Puncture by latched rate and phase. Bits are written in order listed; A precedes B.
  - rate 0 (1/2): phase stays 0; write A,B.
  - rate 1 (2/3): phase 0 writes A,B; phase 1 writes A only. Phase wraps 1->0.
  - rate 2 (3/4): phase 0 writes A,B; phase 1 writes A only; phase 2 writes B only. Phase wraps 2->0.
  - Phase advances only on accept beats.
- FIFO:
  - write 1 or 2 bits per accept beat; zero-latency show-ahead read.
  - out_valid = en & (count != 0); out_bit = head entry.
  - pop when out_valid & out_ready.
  - Simultaneous write and pop in one cycle: count += written - popped.
  - Wrap-around on pointers is modulo FIFO_DEPTH.
  - The FIFO is never overrun, because the in_ready rule guarantees at least 2 free slots on any accept beat.
- Latency: a bit accepted at edge n is visible on out_bit after edge n, provided the FIFO was empty before it.
- Throughput at rate 1/2 with out_ready=1: one input bit every 2 cycles on average, backpressured by in_ready.
- Reset asserted mid-frame: all queued bits are discarded. The next frame must start with sof; without sof, encoding continues from zero state at phase 0 with rate 0.

Test Plan:
- Impulse, rate 0: sof=1 with bit 1, then six 0s, out_ready=1 -> out stream A/B pairs 11 01 11 11 00 10 11 (A=1011011, B=1111001).
- Impulse, rate 2: bits 1,0,0,0,0,0 with sof on the first bit -> stream 1,1,0,1, 1,1,0,0 (8 bits for 6 inputs).
- Rate 1 on an all-ones input of 4 bits from sof -> exactly 6 output bits, with an A,B,A,A,B,A pattern; cross-check against a reference model.
- Backpressure: out_ready=0 with rate 0 -> fifo_count reaches 8 after 4 accepts, then in_ready=0. Raise out_ready -> drains in order with no loss or duplication.
- sof with rate=3 -> rate_err high for exactly one cycle; output identical to rate 0.
- Assert reset mid-frame with 5 bits queued -> fifo_count=0 and out_valid=0 immediately (asynchronous). Next sof frame matches the impulse test.
